egg_timer_ctrl: RTL and testbench



---
 rtl/egg_timer_if.sv | 24 ++
 rtl/egg_timer_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_egg_timer_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/egg_timer_if.sv
// rtl/egg_timer_if.sv - button/strobe inputs and display/alarm outputs of the egg timer controller
interface egg_timer_if #(
    parameter int FIELDS = 2
);
    logic                  sec_tick;
    logic [FIELDS-1:0]     inc_btn;
    logic                  start_btn;
    logic                  clear_btn;
    logic [8*FIELDS-1:0]   time_bcd;
    logic [1:0]            state;
    logic                  running;
    logic                  alarm;
    logic                  done_pulse;

    modport master (
        output sec_tick, inc_btn, start_btn, clear_btn,
        input  time_bcd, state, running, alarm, done_pulse
    );

    modport slave (
        input  sec_tick, inc_btn, start_btn, clear_btn,
        output time_bcd, state, running, alarm, done_pulse
    );
endinterface

// File: rtl/egg_timer_ctrl.sv
// rtl/egg_timer_ctrl.sv - SET/RUN/PAUSE/DONE egg timer with BCD countdown, hold-repeat and alarm (option: EGG_TIMER_RELOAD_EN)
module egg_timer_ctrl #(
    parameter int FIELDS     = 2,
    parameter int HOLD_TICKS = 2,
    parameter int ALARM_SECS = 10
) (
    input  logic          pulse_500Hz,
    input  logic          reset,
    egg_timer_if.slave    tif
);
    typedef enum logic [1:0] {ST_SET = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_DONE = 2'd3} state_t;

    state_t                     state_q, state_d;
    logic [8*FIELDS-1:0]        time_q, time_d;
    logic                       done_q, done_d;
    logic [FIELDS-1:0][3:0]     hold_q, hold_d;
    logic [7:0]                 alarm_cnt_q, alarm_cnt_d;
    logic [FIELDS-1:0]          inc_q;
    logic                       start_q, clear_q;
    logic [FIELDS-1:0]          inc_edge;
    logic                       start_edge, clear_edge;
    logic [8*FIELDS-1:0]        dec_val;
    logic [8*FIELDS-1:0]        exit_time;

    assign inc_edge   = tif.inc_btn & ~inc_q;
    assign start_edge = tif.start_btn & ~start_q;
    assign clear_edge = tif.clear_btn & ~clear_q;

    // One field step up: ones wrap 9->0 into tens, tens wrap 5->0, never carries out
    function automatic logic [7:0] inc_field(input logic [7:0] f);
        logic [7:0] r;
        r = f;
        if (f[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (f[7:4] == 4'd5) ? 4'd0 : f[7:4] + 4'd1;
        end else begin
            r[3:0] = f[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Subtract one second across all base-60 fields with borrow
    function automatic logic [8*FIELDS-1:0] dec_time(input logic [8*FIELDS-1:0] t);
        logic [8*FIELDS-1:0] r;
        logic                borrow;
        r      = t;
        borrow = 1'b1;
        for (int i = 0; i < FIELDS; i++) begin
            if (borrow) begin
                if (r[8*i +: 4] != 4'd0) begin
                    r[8*i +: 4] = r[8*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end else begin
                    r[8*i +: 4] = 4'd9;
                    if (r[8*i+4 +: 4] != 4'd0) begin
                        r[8*i+4 +: 4] = r[8*i+4 +: 4] - 4'd1;
                        borrow        = 1'b0;
                    end else begin
                        r[8*i+4 +: 4] = 4'd5;
                    end
                end
            end
        end
        return r;
    endfunction

    assign dec_val = dec_time(time_q);

`ifdef EGG_TIMER_RELOAD_EN
    logic [8*FIELDS-1:0] reload_q;

    // Capture the programmed time at every start from SET so DONE can restore it
    always_ff @(posedge pulse_500Hz) begin
        if (reset) begin
            reload_q <= '0;
        end else if (state_q == ST_SET && state_d == ST_RUN) begin
            reload_q <= time_q;
        end
    end

    assign exit_time = reload_q;
`else
    assign exit_time = '0;
`endif

    // State, time, counters and button history registers
    always_ff @(posedge pulse_500Hz) begin
        if (reset) begin
            state_q     <= ST_SET;
            time_q      <= '0;
            done_q      <= 1'b0;
            hold_q      <= '0;
            alarm_cnt_q <= '0;
            inc_q       <= '0;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            done_q      <= done_d;
            hold_q      <= hold_d;
            alarm_cnt_q <= alarm_cnt_d;
            inc_q       <= tif.inc_btn;
            start_q     <= tif.start_btn;
            clear_q     <= tif.clear_btn;
        end
    end

    // Next state: clear edge beats start edge beats inc beats sec_tick
    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        done_d      = 1'b0;
        hold_d      = hold_q;
        alarm_cnt_d = '0;
        for (int i = 0; i < FIELDS; i++) begin
            if (!tif.inc_btn[i] || state_q != ST_SET) begin
                hold_d[i] = '0;
            end
        end
        if (clear_edge) begin
            state_d = ST_SET;
            time_d  = '0;
        end else begin
            case (state_q)
                ST_SET: begin
                    if (start_edge) begin
                        if (time_q != '0) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        for (int i = 0; i < FIELDS; i++) begin
                            if (inc_edge[i]) begin
                                time_d[8*i +: 8] = inc_field(time_q[8*i +: 8]);
                            end else if (tif.inc_btn[i] && tif.sec_tick) begin
                                if (hold_q[i] >= 4'(HOLD_TICKS - 1)) begin
                                    time_d[8*i +: 8] = inc_field(time_q[8*i +: 8]);
                                end else begin
                                    hold_d[i] = hold_q[i] + 4'd1;
                                end
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (start_edge) begin
                        state_d = ST_PAUSE;
                    end else if (tif.sec_tick) begin
                        time_d = dec_val;
                        if (dec_val == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start_edge) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    alarm_cnt_d = alarm_cnt_q;
                    if (start_edge || (|inc_edge)) begin
                        state_d     = ST_SET;
                        time_d      = exit_time;
                        alarm_cnt_d = '0;
                    end else if (tif.sec_tick) begin
                        if (alarm_cnt_q == 8'(ALARM_SECS - 1)) begin
                            state_d     = ST_SET;
                            time_d      = exit_time;
                            alarm_cnt_d = '0;
                        end else begin
                            alarm_cnt_d = alarm_cnt_q + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign tif.time_bcd   = time_q;
    assign tif.state      = state_q;
    assign tif.running    = (state_q == ST_RUN);
    assign tif.alarm      = (state_q == ST_DONE);
    assign tif.done_pulse = done_q;
endmodule

// File: tb/tb_egg_timer_ctrl.sv
// tb/tb_egg_timer_ctrl.sv - directed bench with a seconds-arithmetic model of egg_timer_ctrl
module tb_egg_timer_ctrl;
    localparam int FIELDS     = 2;
    localparam int HOLD_TICKS = 2;
    localparam int ALARM_SECS = 10;

    logic pulse_500Hz = 1'b0;
    logic reset       = 1'b1;
    int   checks      = 0;
    int   failures    = 0;

    egg_timer_if #(.FIELDS(FIELDS)) tif ();

    egg_timer_ctrl #(.FIELDS(FIELDS), .HOLD_TICKS(HOLD_TICKS), .ALARM_SECS(ALARM_SECS)) dut (
        .pulse_500Hz (pulse_500Hz),
        .reset       (reset),
        .tif         (tif)
    );

    always #5 pulse_500Hz = ~pulse_500Hz;

    // Model: field values as plain integers, state as a number 0..3
    int m_f [FIELDS];
    int m_reload [FIELDS];
    int m_held [FIELDS];
    int m_state, m_acnt;
    bit m_done, m_valid;
    logic [FIELDS-1:0] p_inc;
    logic p_start, p_clear;

    function automatic int total_secs();
        int t = 0;
        for (int i = 0; i < FIELDS; i++) t += m_f[i] * (60 ** i);
        return t;
    endfunction

    function automatic logic [8*FIELDS-1:0] model_bcd();
        logic [8*FIELDS-1:0] r;
        for (int i = 0; i < FIELDS; i++) begin
            r[8*i +: 8] = {4'(m_f[i] / 10), 4'(m_f[i] % 10)};
        end
        return r;
    endfunction

    task automatic leave_done();
        m_state = 0;
        m_acnt  = 0;
        for (int i = 0; i < FIELDS; i++) begin
`ifdef EGG_TIMER_RELOAD_EN
            m_f[i] = m_reload[i];
`else
            m_f[i] = 0;
`endif
        end
    endtask

    task automatic model_step();
        logic [FIELDS-1:0] ie;
        bit se, ce;
        int t;
        ie = tif.inc_btn & ~p_inc;
        se = tif.start_btn & ~p_start;
        ce = tif.clear_btn & ~p_clear;
        m_done = 0;
        if (reset) begin
            for (int i = 0; i < FIELDS; i++) begin
                m_f[i] = 0; m_reload[i] = 0; m_held[i] = 0;
            end
            m_state = 0; m_acnt = 0; m_valid = 1;
            p_inc = '0; p_start = 0; p_clear = 0;
            return;
        end
        for (int i = 0; i < FIELDS; i++) if (!tif.inc_btn[i] || m_state != 0) m_held[i] = 0;
        if (ce) begin
            m_state = 0;
            for (int i = 0; i < FIELDS; i++) m_f[i] = 0;
        end else if (m_state == 0) begin
            if (se) begin
                if (total_secs() != 0) begin
                    m_state = 1;
                    for (int i = 0; i < FIELDS; i++) m_reload[i] = m_f[i];
                end
            end else begin
                for (int i = 0; i < FIELDS; i++) begin
                    if (ie[i]) m_f[i] = (m_f[i] + 1) % 60;
                    else if (tif.inc_btn[i] && tif.sec_tick) begin
                        m_held[i]++;
                        if (m_held[i] >= HOLD_TICKS) m_f[i] = (m_f[i] + 1) % 60;
                    end
                end
            end
        end else if (m_state == 1) begin
            if (se) m_state = 2;
            else if (tif.sec_tick) begin
                t = total_secs() - 1;
                for (int i = 0; i < FIELDS; i++) m_f[i] = (t / (60 ** i)) % 60;
                if (t == 0) begin m_state = 3; m_done = 1; m_acnt = 0; end
            end
        end else if (m_state == 2) begin
            if (se) m_state = 1;
        end else begin
            if (se || ie != '0) leave_done();
            else if (tif.sec_tick) begin
                m_acnt++;
                if (m_acnt == ALARM_SECS) leave_done();
            end
        end
        p_inc = tif.inc_btn; p_start = tif.start_btn; p_clear = tif.clear_btn;
    endtask

    always @(posedge pulse_500Hz) model_step();

    // Every cycle after the first reset edge the DUT must match the model
    always @(negedge pulse_500Hz) begin
        logic [8*FIELDS+4:0] got, exp;
        if (m_valid) begin
            exp = {model_bcd(), 2'(m_state), m_state == 1, m_state == 3, m_done};
            got = {tif.time_bcd, tif.state, tif.running, tif.alarm, tif.done_pulse};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, got, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge pulse_500Hz);
    endtask

    task automatic tick();
        tif.sec_tick = 1'b1; step(1);
        tif.sec_tick = 1'b0; step(1);
    endtask

    task automatic press_start();
        tif.start_btn = 1'b1; step(1);
        tif.start_btn = 1'b0; step(1);
    endtask

    task automatic press_clear();
        tif.clear_btn = 1'b1; step(1);
        tif.clear_btn = 1'b0; step(1);
    endtask

    task automatic press_inc(input int f, input int n);
        for (int k = 0; k < n; k++) begin
            tif.inc_btn[f] = 1'b1; step(1);
            tif.inc_btn[f] = 1'b0; step(1);
        end
    endtask

    initial begin
        tif.sec_tick = 0; tif.inc_btn = '0; tif.start_btn = 0; tif.clear_btn = 0;
        step(2);
        reset = 1'b0;
        step(1);
        chk("reset_time", 32'(tif.time_bcd), 32'h0);
        chk("reset_state", 32'(tif.state), 32'd0);

        // 00:03 countdown into DONE
        press_inc(0, 3);
        chk("set_0003", 32'(tif.time_bcd), 32'h0003);
        press_start();
        chk("run_state", 32'(tif.state), 32'd1);
        tick();
        chk("cd_0002", 32'(tif.time_bcd), 32'h0002);
        tick();
        chk("cd_0001", 32'(tif.time_bcd), 32'h0001);
        tif.sec_tick = 1'b1; step(1);
        chk("done_state", 32'(tif.state), 32'd3);
        chk("done_pulse", 32'(tif.done_pulse), 32'd1);
        chk("done_alarm", 32'(tif.alarm), 32'd1);
        chk("done_time", 32'(tif.time_bcd), 32'h0000);
        tif.sec_tick = 1'b0; step(1);
        chk("done_pulse_drop", 32'(tif.done_pulse), 32'd0);
        tick(); tick(); tick();
        press_start();
        chk("ack_state", 32'(tif.state), 32'd0);
        chk("ack_alarm", 32'(tif.alarm), 32'd0);
`ifdef EGG_TIMER_RELOAD_EN
        chk("ack_time", 32'(tif.time_bcd), 32'h0003);
`else
        chk("ack_time", 32'(tif.time_bcd), 32'h0000);
`endif

        // Borrow across fields and within a field
        press_clear();
        press_inc(1, 1);
        press_start();
        tick();
        chk("borrow_0059", 32'(tif.time_bcd), 32'h0059);
        press_clear();
        chk("clear_run_state", 32'(tif.state), 32'd0);
        chk("clear_run_time", 32'(tif.time_bcd), 32'h0000);
        press_inc(0, 10);
        press_start();
        tick();
        chk("borrow_0009", 32'(tif.time_bcd), 32'h0009);
        press_clear();

        // Hold-to-repeat from 00:58
        press_inc(0, 58);
        tif.inc_btn[0] = 1'b1; step(1);
        chk("hold_edge", 32'(tif.time_bcd), 32'h0059);
        tick();
        chk("hold_t1", 32'(tif.time_bcd), 32'h0059);
        tick();
        chk("hold_t2", 32'(tif.time_bcd), 32'h0000);
        tick();
        chk("hold_t3", 32'(tif.time_bcd), 32'h0001);
        tick();
        chk("hold_t4", 32'(tif.time_bcd), 32'h0002);
        tick();
        chk("hold_t5", 32'(tif.time_bcd), 32'h0003);
        tif.inc_btn[0] = 1'b0; step(1);
        press_clear();

        // Pause coincident with a tick
        press_inc(0, 5);
        press_start();
        tif.start_btn = 1'b1; tif.sec_tick = 1'b1; step(1);
        chk("pause_state", 32'(tif.state), 32'd2);
        chk("pause_time", 32'(tif.time_bcd), 32'h0005);
        tif.start_btn = 1'b0; tif.sec_tick = 1'b0; step(1);
        tick(); tick();
        chk("pause_frozen", 32'(tif.time_bcd), 32'h0005);
        press_start();
        chk("resume_state", 32'(tif.state), 32'd1);
        tick();
        chk("resume_0004", 32'(tif.time_bcd), 32'h0004);

        // Start with zero time stays in SET
        press_clear();
        press_start();
        chk("start_zero", 32'(tif.state), 32'd0);

        // Alarm timeout after ALARM_SECS ticks
        press_inc(0, 1);
        press_start();
        tick();
        chk("to_done", 32'(tif.state), 32'd3);
        for (int k = 0; k < ALARM_SECS - 1; k++) tick();
        chk("alarm_hold", 32'(tif.alarm), 32'd1);
        tick();
        chk("alarm_timeout", 32'(tif.state), 32'd0);
`ifdef EGG_TIMER_RELOAD_EN
        chk("timeout_time", 32'(tif.time_bcd), 32'h0001);
`else
        chk("timeout_time", 32'(tif.time_bcd), 32'h0000);
`endif

        // Reset while paused
        press_clear();
        press_inc(0, 4);
        press_start();
        press_start();
        chk("pre_reset_pause", 32'(tif.state), 32'd2);
        reset = 1'b1; step(1);
        chk("rst_time", 32'(tif.time_bcd), 32'h0);
        chk("rst_state", 32'(tif.state), 32'd0);
        chk("rst_alarm", 32'(tif.alarm), 32'd0);
        reset = 1'b0; step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
